// File: rtl/vga_timing_gen.sv
// Programmable video timing generator: HS/VS/BLANK from porch/pulse parameters,
// with a per-frame pixel source (grid, colour bars, gradient or external stream).
module vga_timing_gen #(
    parameter int HDISP     = 800,
    parameter int VDISP     = 480,
    parameter int HFP       = 40,
    parameter int HPULSE    = 48,
    parameter int HBP       = 40,
    parameter int VFP       = 13,
    parameter int VPULSE    = 3,
    parameter int VBP       = 29,
    parameter int GRID_LOG2 = 4,
    parameter int HS_POL    = 0,
    parameter int VS_POL    = 0,
    localparam int XW       = $clog2(HDISP),
    localparam int YW       = $clog2(VDISP)
) (
    input  logic          pixel_clk,
    input  logic          pixel_rst,
    input  logic          enable,
    input  logic [1:0]    mode,
    input  logic [23:0]   pix_data,
    input  logic          pix_valid,
    output logic          pix_ready,
    input  logic          underflow_clr,
    output logic          HS,
    output logic          VS,
    output logic          BLANK,
    output logic [23:0]   RGB,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          frame_start,
    output logic          underflow
);
    localparam int HTOTAL = HFP + HPULSE + HBP + HDISP;
    localparam int VTOTAL = VFP + VPULSE + VBP + VDISP;
    localparam int HACT0  = HFP + HPULSE + HBP;
    localparam int VACT0  = VFP + VPULSE + VBP;
    localparam int HW     = $clog2(HTOTAL);
    localparam int VW     = $clog2(VTOTAL);
    localparam int BAR_W  = HDISP / 8;
    localparam int BW     = $clog2(BAR_W + 1);
    localparam logic HS_ON = (HS_POL != 0);
    localparam logic VS_ON = (VS_POL != 0);

    logic [HW-1:0] h_q, h_d, xa;
    logic [VW-1:0] v_q, v_d, ya;
    logic [1:0]    mode_q;
    logic [2:0]    bar_idx_q, bar_idx_d;
    logic [BW-1:0] bar_pos_q, bar_pos_d;
    logic          hs_q, vs_q, blank_q, fs_q, uf_q;
    logic          hs_d, vs_d, fs_d, uf_d, active;
    logic [23:0]   rgb_q, rgb_d, bar_rgb;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [7:0]    gx, gy;

    assign active    = (h_q >= HW'(HACT0)) && (v_q >= VW'(VACT0));
    assign pix_ready = enable && active && (mode_q == 2'd3);

    always_comb begin
        h_d = (h_q == HW'(HTOTAL - 1)) ? '0 : h_q + 1'b1;
        v_d = v_q;
        if (h_q == HW'(HTOTAL - 1))
            v_d = (v_q == VW'(VTOTAL - 1)) ? '0 : v_q + 1'b1;
        xa   = h_q - HW'(HACT0);
        ya   = v_q - VW'(VACT0);
        x_d  = active ? XW'(xa) : '0;
        y_d  = active ? YW'(ya) : '0;
        gx   = 8'(xa);
        gy   = 8'(ya);
        hs_d = (h_q >= HW'(HFP) && h_q < HW'(HFP + HPULSE)) ? HS_ON : !HS_ON;
        vs_d = (v_q >= VW'(VFP) && v_q < VW'(VFP + VPULSE)) ? VS_ON : !VS_ON;
        fs_d = (h_q == '0) && (v_q == '0);

        // Bar index tracks the current pixel; counted rather than divided.
        bar_idx_d = '0;
        bar_pos_d = '0;
        if (active) begin
            bar_idx_d = bar_idx_q;
            bar_pos_d = bar_pos_q + 1'b1;
            if (bar_pos_q == BW'(BAR_W - 1)) begin
                bar_pos_d = '0;
                if (bar_idx_q != 3'd7) bar_idx_d = bar_idx_q + 3'd1;
            end
        end
        case (bar_idx_q)
            3'd0:    bar_rgb = 24'hFFFFFF;
            3'd1:    bar_rgb = 24'hFFFF00;
            3'd2:    bar_rgb = 24'h00FFFF;
            3'd3:    bar_rgb = 24'h00FF00;
            3'd4:    bar_rgb = 24'hFF00FF;
            3'd5:    bar_rgb = 24'hFF0000;
            3'd6:    bar_rgb = 24'h0000FF;
            default: bar_rgb = 24'h000000;
        endcase

        rgb_d = '0;
        if (active) begin
            case (mode_q)
                2'd0: rgb_d = (xa[GRID_LOG2-1:0] == '0 || ya[GRID_LOG2-1:0] == '0)
                              ? 24'hFFFFFF : 24'h000000;
                2'd1: rgb_d = bar_rgb;
                2'd2: rgb_d = {gx, gy, gx + gy};
                default: rgb_d = pix_valid ? pix_data : 24'hFF00FF;
            endcase
        end

        // A new underflow wins over a simultaneous clear.
        uf_d = uf_q;
        if (pix_ready && !pix_valid) uf_d = 1'b1;
        else if (underflow_clr)      uf_d = 1'b0;
    end

    always_ff @(posedge pixel_clk or negedge pixel_rst) begin
        if (!pixel_rst) begin
            h_q <= '0; v_q <= '0; mode_q <= '0;
            bar_idx_q <= '0; bar_pos_q <= '0;
            hs_q <= !HS_ON; vs_q <= !VS_ON; blank_q <= 1'b0; fs_q <= 1'b0;
            uf_q <= 1'b0; rgb_q <= '0; x_q <= '0; y_q <= '0;
        end else if (!enable) begin
            h_q <= '0; v_q <= '0;
            bar_idx_q <= '0; bar_pos_q <= '0;
            hs_q <= !HS_ON; vs_q <= !VS_ON; blank_q <= 1'b0; fs_q <= 1'b0;
            uf_q <= 1'b0; rgb_q <= '0; x_q <= '0; y_q <= '0;
        end else begin
            h_q <= h_d; v_q <= v_d;
            if (fs_d) mode_q <= mode;
            bar_idx_q <= bar_idx_d; bar_pos_q <= bar_pos_d;
            hs_q <= hs_d; vs_q <= vs_d; blank_q <= active; fs_q <= fs_d;
            uf_q <= uf_d; rgb_q <= rgb_d; x_q <= x_d; y_q <= y_d;
        end
    end

    assign HS          = hs_q;
    assign VS          = vs_q;
    assign BLANK       = blank_q;
    assign RGB         = rgb_q;
    assign x           = x_q;
    assign y           = y_q;
    assign frame_start = fs_q;
    assign underflow   = uf_q;
endmodule
